// File: rtl/dnn_feeder.sv
// dnn_feeder: streams a 24-word weight set and 4 inputs into registers, fires the network stage, then waits for its result.
module dnn_feeder #(
  parameter int I_W     = 7,
  parameter int TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           s_valid,
  input  logic [I_W-1:0] s_data,
  input  logic           s_keep_w,
  output logic           s_ready,
  output logic [I_W-1:0] x0,
  output logic [I_W-1:0] x1,
  output logic [I_W-1:0] x2,
  output logic [I_W-1:0] x3,
  output logic [4:0]     w04,
  output logic [4:0]     w05,
  output logic [4:0]     w06,
  output logic [4:0]     w07,
  output logic [4:0]     w14,
  output logic [4:0]     w15,
  output logic [4:0]     w16,
  output logic [4:0]     w17,
  output logic [4:0]     w24,
  output logic [4:0]     w25,
  output logic [4:0]     w26,
  output logic [4:0]     w27,
  output logic [4:0]     w34,
  output logic [4:0]     w35,
  output logic [4:0]     w36,
  output logic [4:0]     w37,
  output logic [4:0]     w48,
  output logic [4:0]     w49,
  output logic [4:0]     w58,
  output logic [4:0]     w59,
  output logic [4:0]     w68,
  output logic [4:0]     w69,
  output logic [4:0]     w78,
  output logic [4:0]     w79,
  output logic           in_ready,
  input  logic           res_ready,
  output logic           busy,
  output logic           err
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, LOAD_W, LOAD_X, FIRE, WAIT} state_t;
  state_t         state_q;
  logic [4:0]     cnt_q;
  logic [TW-1:0]  tcnt_q;
  logic           wvalid_q, res_q, err_q, in_ready_q;
  logic [4:0]     w_q [24];
  logic [I_W-1:0] x_q [4];
  logic           acc, rise;
  assign s_ready  = ~rst & (state_q == IDLE || state_q == LOAD_W || state_q == LOAD_X);
  assign acc      = s_valid & s_ready;
  assign rise     = res_ready & ~res_q;
  assign busy     = state_q != IDLE;
  assign err      = err_q;
  assign in_ready = in_ready_q;
  // The first word is stored while leaving IDLE, so the load states resume at index 1
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      wvalid_q   <= 1'b0;
      res_q      <= 1'b0;
      err_q      <= 1'b0;
      in_ready_q <= 1'b0;
      for (int i = 0; i < 24; i++) w_q[i] <= '0;
      for (int i = 0; i < 4; i++) x_q[i] <= '0;
    end else begin
      res_q      <= res_ready;
      in_ready_q <= 1'b0;
      case (state_q)
        IDLE: if (acc) begin
          cnt_q <= 5'd1;
          if (s_keep_w && wvalid_q) begin
            x_q[0]  <= s_data;
            state_q <= LOAD_X;
          end else begin
            w_q[0]  <= s_data[4:0];
            state_q <= LOAD_W;
          end
        end
        LOAD_W: if (acc) begin
          w_q[cnt_q] <= s_data[4:0];
          if (cnt_q == 5'd23) begin
            cnt_q    <= '0;
            wvalid_q <= 1'b1;
            state_q  <= LOAD_X;
          end else cnt_q <= cnt_q + 5'd1;
        end
        LOAD_X: if (acc) begin
          x_q[cnt_q[1:0]] <= s_data;
          if (cnt_q == 5'd3) begin
            cnt_q      <= '0;
            in_ready_q <= 1'b1;
            state_q    <= FIRE;
          end else cnt_q <= cnt_q + 5'd1;
        end
        FIRE: begin
          tcnt_q  <= '0;
          state_q <= WAIT;
        end
        WAIT: if (rise) state_q <= IDLE;
        else if (tcnt_q == T_LAST) begin
          err_q   <= 1'b1;
          state_q <= IDLE;
        end else tcnt_q <= tcnt_q + 1'b1;
        default: state_q <= IDLE;
      endcase
    end
  end
  assign x0 = x_q[0];
  assign x1 = x_q[1];
  assign x2 = x_q[2];
  assign x3 = x_q[3];
  assign w04 = w_q[0];
  assign w05 = w_q[1];
  assign w06 = w_q[2];
  assign w07 = w_q[3];
  assign w14 = w_q[4];
  assign w15 = w_q[5];
  assign w16 = w_q[6];
  assign w17 = w_q[7];
  assign w24 = w_q[8];
  assign w25 = w_q[9];
  assign w26 = w_q[10];
  assign w27 = w_q[11];
  assign w34 = w_q[12];
  assign w35 = w_q[13];
  assign w36 = w_q[14];
  assign w37 = w_q[15];
  assign w48 = w_q[16];
  assign w58 = w_q[17];
  assign w68 = w_q[18];
  assign w78 = w_q[19];
  assign w49 = w_q[20];
  assign w59 = w_q[21];
  assign w69 = w_q[22];
  assign w79 = w_q[23];
endmodule

// File: tb/tb_dnn_feeder.sv
// tb_dnn_feeder: directed frames with a queue scoreboard checked on every in_ready pulse.
module tb_dnn_feeder;
  localparam int TO = 64;
  logic clk = 1'b0, rst = 1'b1, s_valid = 1'b0, s_keep_w = 1'b0, res_ready = 1'b0;
  logic [6:0] s_data = '0;
  logic s_ready, in_ready, busy, err;
  logic [6:0] x0, x1, x2, x3;
  logic [4:0] w04, w05, w06, w07, w14, w15, w16, w17, w24, w25, w26, w27;
  logic [4:0] w34, w35, w36, w37, w48, w49, w58, w59, w68, w69, w78, w79;
  int total = 0, bad = 0, cyc = 0, first_cyc = 0, fire_cyc = 0;
  logic [147:0] exp_q [$];
  logic [4:0] wt [2][24];
  logic [6:0] xt [3][4];
  logic [4:0] mw [24];
  logic [6:0] mx [4];
  logic mwv = 1'b0;

  dnn_feeder #(.I_W(7), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_data(s_data), .s_keep_w(s_keep_w), .s_ready(s_ready),
    .x0(x0), .x1(x1), .x2(x2), .x3(x3),
    .w04(w04), .w05(w05), .w06(w06), .w07(w07), .w14(w14), .w15(w15), .w16(w16), .w17(w17),
    .w24(w24), .w25(w25), .w26(w26), .w27(w27), .w34(w34), .w35(w35), .w36(w36), .w37(w37),
    .w48(w48), .w49(w49), .w58(w58), .w59(w59), .w68(w68), .w69(w69), .w78(w78), .w79(w79),
    .in_ready(in_ready), .res_ready(res_ready), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(string n, logic [255:0] got, logic [255:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", n, got, want);
    end
  endfunction

  function automatic logic [147:0] dut_snap();
    return {x0, x1, x2, x3, w04, w05, w06, w07, w14, w15, w16, w17, w24, w25, w26, w27,
            w34, w35, w36, w37, w48, w58, w68, w78, w49, w59, w69, w79};
  endfunction

  function automatic logic [147:0] model_snap();
    logic [147:0] s = '0;
    for (int i = 0; i < 4; i++) s = (s << 7) | 148'(mx[i]);
    for (int i = 0; i < 24; i++) s = (s << 5) | 148'(mw[i]);
    return s;
  endfunction

  // Scoreboard monitor: every in_ready pulse must match the oldest expected snapshot
  always @(negedge clk) begin
    if (!rst && in_ready) begin
      if (exp_q.size() == 0) chk("unexpected_in_ready", 1, 0);
      else chk("fire_snapshot", dut_snap(), exp_q.pop_front());
    end
  end

  task automatic push_word(input logic [6:0] d, input logic k, input bit gaps, input bit first);
    int n = 0;
    if (gaps) repeat ($urandom_range(0, 2)) begin
      s_valid = 1'b0;
      s_data = 7'($urandom);
      @(posedge clk); #1;
    end
    s_valid = 1'b1; s_data = d; s_keep_w = k;
    while (!s_ready) begin
      @(posedge clk); #1;
      if (++n > 200) begin
        $display("FAIL accept_timeout got=%0d want=<200", n);
        $fatal(1, "no accept");
      end
    end
    if (first) first_cyc = cyc;
    @(posedge clk); #1;
    s_valid = 1'b0; s_keep_w = 1'b0;
  endtask

  // Sends one frame; nw limits the number of words to model an aborted frame
  task automatic frame(input logic k, input int wi, input int xi, input bit gaps, input int nw);
    logic full = !(k && mwv);
    int sent = 0;
    if (full) begin mw = wt[wi]; mwv = 1'b1; end
    mx = xt[xi];
    if (nw >= 28) exp_q.push_back(model_snap());
    if (full) for (int i = 0; i < 24 && sent < nw; i++) begin
      push_word({{2{wt[wi][i][4]}}, wt[wi][i]}, sent == 0 ? k : ~k, gaps, sent == 0);
      sent++;
    end
    for (int i = 0; i < 4 && sent < nw; i++) begin
      push_word(xt[xi][i], sent == 0 ? k : ~k, gaps, sent == 0);
      sent++;
    end
  endtask

  task automatic wait_fire(input string n, input int want_len);
    int m = 0;
    while (m < 300) begin
      @(negedge clk);
      if (in_ready) break;
      m++;
    end
    fire_cyc = cyc;
    chk({n, "_fire_seen"}, m < 300, 1);
    if (want_len > 0) chk({n, "_frame_cycles"}, fire_cyc - first_cyc + 1, want_len);
  endtask

  task automatic finish_rise(input string n);
    @(posedge clk); #1;
    chk({n, "_wait_state"}, {in_ready, busy}, 2'b01);
    res_ready = 1'b0;
    @(posedge clk); #1;
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk({n, "_done_idle"}, {busy, s_ready}, 2'b01);
    res_ready = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 24; i++) begin
      wt[0][i] = 5'(i + 1);
      wt[1][i] = 5'(7 * i - 13);
    end
    xt[0] = '{7'd3, -7'sd2, 7'd5, -7'sd64};
    xt[1] = '{7'd1, 7'd1, 7'd1, 7'd1};
    xt[2] = '{-7'sd1, 7'd63, -7'sd30, 7'd17};
    repeat (3) @(posedge clk); #1;
    chk("rst_outputs", {s_ready, in_ready, busy, err}, 4'b0000);
    chk("rst_regs", dut_snap(), 0);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", {s_ready, busy}, 2'b10);

    frame(1'b0, 0, 0, 1'b0, 28);
    wait_fire("full", 29);
    chk("w04_is_1", w04, 5'd1);
    chk("w79_is_m8", w79, 5'b11000);
    chk("x3_is_m64", x3, 7'b1000000);
    finish_rise("full");
    chk("no_err_after_rise", err, 0);

    frame(1'b1, 1, 1, 1'b0, 28);
    wait_fire("keep", 5);
    finish_rise("keep");

    frame(1'b1, 1, 2, 1'b0, 28);
    wait_fire("tie", 5);
    @(posedge clk); #1;
    res_ready = 1'b0;
    repeat (TO - 1) @(posedge clk);
    #1;
    chk("tie_still_waiting", busy, 1);
    res_ready = 1'b1;
    @(posedge clk); #1;
    chk("tie_edge_wins", {busy, err}, 2'b00);

    frame(1'b1, 1, 0, 1'b0, 28);
    wait_fire("timeout", 5);
    begin
      int n = 0;
      while (!err && n < 200) begin @(posedge clk); #1; n++; end
      chk("timeout_cycles", n, TO + 1);
      chk("timeout_idle", busy, 0);
    end
    res_ready = 1'b0;

    frame(1'b0, 1, 2, 1'b1, 28);
    wait_fire("gap1", 0);
    finish_rise("gap1");
    frame(1'b1, 0, 0, 1'b1, 28);
    wait_fire("gap2", 0);
    finish_rise("gap2");
    frame(1'b0, 0, 1, 1'b1, 28);
    wait_fire("gap3", 0);
    finish_rise("gap3");
    chk("err_sticky", err, 1);

    frame(1'b0, 1, 2, 1'b0, 10);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_outputs", {s_ready, in_ready, busy, err}, 4'b0000);
    chk("abort_regs", dut_snap(), 0);
    rst = 1'b0;
    mwv = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("abort_no_fire", {in_ready, busy}, 2'b00);
    frame(1'b1, 1, 2, 1'b0, 28);
    wait_fire("reload", 29);
    finish_rise("reload");

    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
